// File: rtl/snake_food_gen.sv
// Food placer for the snake game: draws free-running LFSR candidates, confirms
// each one against the body store, holds the food until eaten, and keeps score.
module snake_food_gen #(
    parameter int         GRID_W    = 16,
    parameter int         GRID_H    = 8,
    parameter int         MAX_TRIES = 8,
    parameter logic [7:0] SEED      = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] headX,
    input  logic [3:0] headY,
    output logic       qryReq,
    output logic [3:0] qryX,
    output logic [3:0] qryY,
    input  logic       qryHit,
    output logic [3:0] foodX,
    output logic [3:0] foodY,
    output logic       foodValid,
    output logic       eaten,
    output logic [7:0] score,
    output logic       full
);

    localparam int         CELLS = GRID_W * GRID_H;
    localparam int         TW    = $clog2(MAX_TRIES + 1);
    localparam int         SW    = $clog2(CELLS + 1);
    localparam logic [4:0] GW5   = 5'(GRID_W);
    localparam logic [4:0] GH5   = 5'(GRID_H);

    typedef enum logic [2:0] {PICK, WAIT, SCAN, ARMED, DONE} state_e;

    state_e        state_q;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [TW-1:0] tries_q;
    logic [SW-1:0] scan_cnt_q;
    logic          scan_chk_q;
    logic [3:0]    cand_x_q, cand_y_q;
    logic [3:0]    food_x_q, food_y_q;
    logic          food_valid_q, eaten_q, qry_req_q, full_q;
    logic [7:0]    score_q;

    logic [3:0]    pick_x, pick_y, nxt_x, nxt_y;
    logic          pick_ok, eat_hit;

    always_comb begin
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        pick_x  = 4'({1'b0, lfsr_q[7:4]} % GW5);
        pick_ok = {1'b0, lfsr_q[3:0]} < GH5;
        // Forced-to-row-0 value is only used when falling back to the scan.
        pick_y  = pick_ok ? lfsr_q[3:0] : 4'd0;
        nxt_x   = cand_x_q + 4'd1;
        nxt_y   = cand_y_q;
        if (cand_x_q == 4'(GRID_W - 1)) begin
            nxt_x = 4'd0;
            nxt_y = (cand_y_q == 4'(GRID_H - 1)) ? 4'd0 : cand_y_q + 4'd1;
        end
        eat_hit = tick && (headX == food_x_q) && (headY == food_y_q);
    end

    // NOTE: every state element here is a register updated with non-blocking
    // assignments so all of them see the same pre-edge values within a cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= PICK;
            lfsr_q       <= SEED;
            tries_q      <= '0;
            scan_cnt_q   <= '0;
            scan_chk_q   <= 1'b0;
            cand_x_q     <= 4'd0;
            cand_y_q     <= 4'd0;
            food_x_q     <= 4'd0;
            food_y_q     <= 4'd0;
            food_valid_q <= 1'b0;
            eaten_q      <= 1'b0;
            qry_req_q    <= 1'b0;
            full_q       <= 1'b0;
            score_q      <= 8'd0;
        end else begin
            lfsr_q    <= lfsr_d;
            qry_req_q <= 1'b0;
            eaten_q   <= 1'b0;
            case (state_q)
                PICK: begin
                    if (tries_q == TW'(MAX_TRIES)) begin
                        cand_x_q   <= pick_x;
                        cand_y_q   <= pick_y;
                        scan_cnt_q <= '0;
                        scan_chk_q <= 1'b0;
                        state_q    <= SCAN;
                    end else if (!pick_ok) begin
                        tries_q <= tries_q + 1'b1;
                    end else begin
                        cand_x_q  <= pick_x;
                        cand_y_q  <= pick_y;
                        qry_req_q <= 1'b1;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (!qryHit) begin
                        food_x_q     <= cand_x_q;
                        food_y_q     <= cand_y_q;
                        food_valid_q <= 1'b1;
                        tries_q      <= '0;
                        state_q      <= ARMED;
                    end else begin
                        tries_q <= tries_q + 1'b1;
                        if (tries_q == TW'(MAX_TRIES - 1)) begin
                            scan_cnt_q <= '0;
                            scan_chk_q <= 1'b0;
                            state_q    <= SCAN;
                        end else begin
                            state_q <= PICK;
                        end
                    end
                end
                SCAN: begin
                    // Two-phase walk: issue the probe, then judge the answer.
                    if (!scan_chk_q) begin
                        if (scan_cnt_q == SW'(CELLS)) begin
                            full_q       <= 1'b1;
                            food_valid_q <= 1'b0;
                            state_q      <= DONE;
                        end else begin
                            qry_req_q  <= 1'b1;
                            scan_chk_q <= 1'b1;
                        end
                    end else begin
                        scan_chk_q <= 1'b0;
                        if (qryHit) begin
                            cand_x_q   <= nxt_x;
                            cand_y_q   <= nxt_y;
                            scan_cnt_q <= scan_cnt_q + 1'b1;
                        end else begin
                            food_x_q     <= cand_x_q;
                            food_y_q     <= cand_y_q;
                            food_valid_q <= 1'b1;
                            tries_q      <= '0;
                            state_q      <= ARMED;
                        end
                    end
                end
                ARMED: begin
                    if (eat_hit) begin
                        eaten_q      <= 1'b1;
                        food_valid_q <= 1'b0;
                        if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                        state_q      <= PICK;
                    end
                end
                DONE: ;
                default: state_q <= PICK;
            endcase
        end
    end

    assign qryReq    = qry_req_q;
    assign qryX      = cand_x_q;
    assign qryY      = cand_y_q;
    assign foodX     = food_x_q;
    assign foodY     = food_y_q;
    assign foodValid = food_valid_q;
    assign eaten     = eaten_q;
    assign score     = score_q;
    assign full      = full_q;

endmodule

// File: tb/tb_snake_food_gen.sv
// Scoreboard bench for snake_food_gen: expected placements and eat scores are
// queued at stimulus time and checked by a negedge monitor as the DUT reports.
module tb_snake_food_gen;

    localparam int         GRID_W    = 16;
    localparam int         GRID_H    = 8;
    localparam int         MAX_TRIES = 8;
    localparam logic [7:0] SEED      = 8'hA5;
    localparam int         CELLS     = GRID_W * GRID_H;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } food_t;

    logic       clk, rst_n, tick, qryReq, qryHit, foodValid, eaten, full;
    logic [3:0] headX, headY, qryX, qryY, foodX, foodY;
    logic [7:0] score;
    logic [CELLS-1:0] occ;

    int total = 0;
    int bad   = 0;
    int probes = 0;
    food_t food_q[$];
    int    eat_q[$];

    snake_food_gen #(.GRID_W(GRID_W), .GRID_H(GRID_H), .MAX_TRIES(MAX_TRIES), .SEED(SEED)) dut (
        .clk(clk), .reset(rst_n), .tick(tick), .headX(headX), .headY(headY),
        .qryReq(qryReq), .qryX(qryX), .qryY(qryY), .qryHit(qryHit),
        .foodX(foodX), .foodY(foodY), .foodValid(foodValid), .eaten(eaten),
        .score(score), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Body store: answers in the same cycle the probe is presented.
    assign qryHit = qryReq && occ[{qryY[2:0], qryX}];

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Placement with an empty board, starting from the LFSR value of the first PICK clock.
    function automatic food_t first_free(input logic [7:0] start);
        logic [7:0] v;
        logic       found;
        food_t      r;
        v = start;
        found = 1'b0;
        r = '0;
        for (int t = 0; t < MAX_TRIES; t++) begin
            if (!found) begin
                if (v[3:0] < 4'(GRID_H)) begin
                    r = food_t'(v);
                    found = 1'b1;
                end else begin
                    v = lfsr_step(v);
                end
            end
        end
        if (!found) r = '{x: v[7:4], y: (v[3:0] < 4'(GRID_H)) ? v[3:0] : 4'd0};
        return r;
    endfunction

    // Random-phase probes issued before the fallback scan when every cell is occupied.
    function automatic int random_probes(input logic [7:0] start);
        logic [7:0] v;
        int n;
        v = start;
        n = 0;
        for (int t = 0; t < MAX_TRIES; t++) begin
            if (v[3:0] < 4'(GRID_H)) begin
                n++;
                v = lfsr_step(lfsr_step(v));
            end else begin
                v = lfsr_step(v);
            end
        end
        return n;
    endfunction

    logic [7:0] m_lfsr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    logic       fv_prev = 1'b0;
    logic [3:0] last_x = 4'd0, last_y = 4'd0;
    food_t      mon_f;
    int         mon_e;

    always @(negedge clk) begin
        if (qryReq) probes <= probes + 1;
        if (rst_n) begin
            if (eaten && qryReq) check("eat_qry_overlap", 1, 0);
            if (eaten) begin
                if (eat_q.size() == 0) check("eat_unexpected", 1, 0);
                else begin
                    mon_e = eat_q.pop_front();
                    check("eat_score", int'(score), mon_e);
                    check("eat_fv_low", int'(foodValid), 0);
                end
            end
            if (foodValid && !fv_prev) begin
                if (food_q.size() == 0) check("food_unexpected", 1, 0);
                else begin
                    mon_f = food_q.pop_front();
                    check("food_x", int'(foodX), int'(mon_f.x));
                    check("food_y", int'(foodY), int'(mon_f.y));
                end
            end
            if (foodValid && fv_prev && (foodX != last_x || foodY != last_y))
                check("food_stable", 1, 0);
        end
        fv_prev <= rst_n && foodValid;
        last_x  <= foodX;
        last_y  <= foodY;
    end

    task automatic wait_fv(input int bound, output int cyc);
        cyc = 0;
        while (!foodValid && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        if (!foodValid) check("fv_timeout", 0, 1);
    endtask

    task automatic do_reset(input logic [CELLS-1:0] mask);
        @(negedge clk);
        rst_n = 1'b0;
        occ   = mask;
        tick  = 1'b0;
        headX = 4'd0;
        headY = 4'd15;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc, lat, base, exp_score;
        logic [CELLS-1:0] mask;
        rst_n = 1'b0;
        tick  = 1'b0;
        headX = 4'd0;
        headY = 4'd15;
        occ   = '1;
        repeat (2) @(negedge clk);
        check("rst_fv", int'(foodValid), 0);
        check("rst_score", int'(score), 0);
        check("rst_full", int'(full), 0);
        check("rst_qry", int'(qryReq), 0);

        // Reset asserted while the fallback scan is probing.
        rst_n = 1'b1;
        base = probes;
        cyc = 0;
        while (!(qryReq && probes >= base + 20) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check("scan_reached", int'(qryReq), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_qry", int'(qryReq), 0);
        check("async_fv", int'(foodValid), 0);
        check("async_xy", int'({foodX, foodY}), 0);
        check("async_score_full", int'({score, full, eaten}), 0);

        // Empty board from SEED: A5 -> x=10, y=5 on the first PICK clock.
        occ = '0;
        food_q.push_back('{x: 4'd10, y: 4'd5});
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        while (!qryReq && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("first_qry_lat", int'(lat >= 1 && lat <= MAX_TRIES + 1), 1);
        wait_fv(MAX_TRIES + 2, cyc);
        check("fv_lat", int'(lat + cyc <= MAX_TRIES + 2), 1);
        check("food_y_range", int'(foodY < 4'(GRID_H)), 1);

        // Tick with the head off the food does nothing.
        headX = 4'd3; headY = 4'd3; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        check("miss_score", int'(score), 0);
        check("miss_fv", int'(foodValid), 1);

        // Eat, then keep ticking on the stale food through PICK/WAIT.
        headX = 4'd10; headY = 4'd5; tick = 1'b1;
        eat_q.push_back(1);
        food_q.push_back(first_free(lfsr_step(m_lfsr)));
        @(negedge clk);
        check("stale_x", int'(foodX), 10);
        check("stale_y", int'(foodY), 5);
        repeat (2) @(negedge clk);
        tick = 1'b0;
        headY = 4'd15;
        check("stale_tick_score", int'(score), 1);

        // Drive the score to saturation.
        for (int i = 2; i <= 256; i++) begin
            wait_fv(300, cyc);
            headX = foodX; headY = foodY; tick = 1'b1;
            exp_score = (i > 255) ? 255 : i;
            eat_q.push_back(exp_score);
            food_q.push_back(first_free(lfsr_step(m_lfsr)));
            @(negedge clk);
            tick = 1'b0;
            headY = 4'd15;
        end
        wait_fv(300, cyc);
        @(negedge clk);
        check("sat_score", int'(score), 255);

        // Only (3,5) is free: the placement must land there.
        mask = '1;
        mask[5*GRID_W + 3] = 1'b0;
        food_q.push_back('{x: 4'd3, y: 4'd5});
        do_reset(mask);
        wait_fv(2*MAX_TRIES + 2*CELLS + 10, cyc);
        @(negedge clk);
        check("scan_x", int'(foodX), 3);
        check("scan_y", int'(foodY), 5);

        // Board full: every cell probed once in the scan, then DONE.
        do_reset('1);
        base = probes;
        cyc = 0;
        while (!full && cyc < 2*MAX_TRIES + 2*CELLS + 10) begin
            @(negedge clk);
            cyc++;
        end
        check("full_set", int'(full), 1);
        check("full_probes", probes - base, random_probes(SEED) + CELLS);
        check("full_fv", int'(foodValid), 0);
        base = probes;
        headX = foodX; headY = foodY; tick = 1'b1;
        repeat (20) @(negedge clk);
        tick = 1'b0;
        check("done_no_qry", probes - base, 0);
        check("done_full", int'(full), 1);
        check("done_score", int'(score), 0);

        check("food_q_drained", food_q.size(), 0);
        check("eat_q_drained", eat_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
